// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Owns the register file's single write port (WE/A3/WD) and shares it among three sources:
// the core writeback path, a debug write port, and an internal clear sequencer. The clear
// sequencer zeroes x1..x(NREG-1). Core and debug requests are served round-robin, and the
// grant is registered as a one-cycle pulse. Every output comes straight from a flop.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   core_req/addr/data  core write request, held until core_gnt
//   core_gnt            one-cycle grant pulse to the core
//   dbg_req/addr/data   debug write request, held until dbg_gnt
//   dbg_gnt             one-cycle grant pulse to debug
//   clr_start           pulse that starts the clear sequence (ignored while busy)
//   clr_busy            high during every clear write
//   clr_done            high during the last clear write
//   rf_we/rf_a3/rf_wd   register file write port
module rf_write_arbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_data,
  output logic          core_gnt,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_gnt,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          rf_we,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [AW-1:0] LastReg  = AW'(NREG - 1);
  localparam logic [AW-1:0] FirstReg = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;         // address being written during a clear
  logic          prefer_dbg_q, prefer_dbg_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_a3_q, rf_a3_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic          core_gnt_q, core_gnt_d;
  logic          dbg_gnt_q, dbg_gnt_d;
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;

  logic core_elig, dbg_elig, pick_core, pick_dbg, arb_en;

  // A requester still seeing its grant is presenting a transaction that has already been
  // consumed, so it is masked for this edge.
  assign core_elig = core_req & ~core_gnt_q;
  assign dbg_elig  = dbg_req & ~dbg_gnt_q;
  assign pick_core = core_elig & (~dbg_elig | ~prefer_dbg_q);
  assign pick_dbg  = dbg_elig & (~core_elig | prefer_dbg_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prefer_dbg_d = prefer_dbg_q;
    rf_we_d      = 1'b0;
    rf_a3_d      = rf_a3_q;
    rf_wd_d      = rf_wd_q;
    core_gnt_d   = 1'b0;
    dbg_gnt_d    = 1'b0;
    clr_busy_d   = 1'b0;
    clr_done_d   = 1'b0;
    arb_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d    = StClear;
          cnt_d      = FirstReg;
          rf_we_d    = 1'b1;
          rf_a3_d    = FirstReg;
          rf_wd_d    = '0;
          clr_busy_d = 1'b1;
          clr_done_d = (FirstReg == LastReg);
        end else begin
          arb_en = 1'b1;
        end
      end
      StClear: begin
        if (cnt_q == LastReg) begin
          // Last clear write retires here; the port is free to arbitrate at this same edge.
          state_d = StIdle;
          cnt_d   = '0;
          arb_en  = 1'b1;
        end else begin
          cnt_d      = cnt_q + FirstReg;
          rf_we_d    = 1'b1;
          rf_a3_d    = cnt_d;
          rf_wd_d    = '0;
          clr_busy_d = 1'b1;
          clr_done_d = (cnt_d == LastReg);
        end
      end
      default: state_d = StIdle;
    endcase

    if (arb_en) begin
      if (pick_core) begin
        core_gnt_d   = 1'b1;
        rf_we_d      = |core_addr;  // x0 writes are consumed but never reach the file
        rf_a3_d      = core_addr;
        rf_wd_d      = core_data;
        prefer_dbg_d = 1'b1;
      end else if (pick_dbg) begin
        dbg_gnt_d    = 1'b1;
        rf_we_d      = |dbg_addr;
        rf_a3_d      = dbg_addr;
        rf_wd_d      = dbg_data;
        prefer_dbg_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      prefer_dbg_q <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd_q      <= '0;
      core_gnt_q   <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prefer_dbg_q <= prefer_dbg_d;
      rf_we_q      <= rf_we_d;
      rf_a3_q      <= rf_a3_d;
      rf_wd_q      <= rf_wd_d;
      core_gnt_q   <= core_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_a3    = rf_a3_q;
  assign rf_wd    = rf_wd_q;
  assign core_gnt = core_gnt_q;
  assign dbg_gnt  = dbg_gnt_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Directed scenarios followed by randomized core/debug/clear traffic. Every cycle, all DUT
// outputs are compared with a behavioural model. The model keeps the clear sequence as a
// queue of pending addresses and the arbitration as a "who is favoured" flag.
module tb_rf_write_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_data = '0;
  logic          core_gnt;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data = '0;
  logic          dbg_gnt;
  logic          clr_start = 1'b0;
  logic          clr_busy, clr_done, rf_we;
  logic [AW-1:0] rf_a3;
  logic [DW-1:0] rf_wd;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .core_req  (core_req),
    .core_addr (core_addr),
    .core_data (core_data),
    .core_gnt  (core_gnt),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_gnt   (dbg_gnt),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit            e_we, e_cg, e_dg, e_busy, e_done;
  logic [AW-1:0] e_a3;
  logic [DW-1:0] e_wd;
  bit            favor_dbg;
  int            clr_queue[$];

  function automatic void model_reset();
    e_we = 0; e_cg = 0; e_dg = 0; e_busy = 0; e_done = 0;
    e_a3 = '0; e_wd = '0;
    favor_dbg = 0;
    clr_queue.delete();
  endfunction

  function automatic void model_edge();
    bit c_ok, d_ok, was_busy, take_core;
    int a;
    c_ok = core_req && !e_cg;
    d_ok = dbg_req && !e_dg;
    was_busy = e_busy;
    e_cg = 0; e_dg = 0; e_we = 0; e_done = 0;
    if (was_busy && clr_queue.size() == 0) e_busy = 0;
    else if (!was_busy && clr_start) begin
      for (int r = 1; r < NREG; r++) clr_queue.push_back(r);
      e_busy = 1;
    end
    if (e_busy) begin
      a = clr_queue.pop_front();
      e_we = 1; e_a3 = AW'(a); e_wd = '0;
      e_done = (clr_queue.size() == 0);
    end else if (c_ok || d_ok) begin
      take_core = (c_ok && d_ok) ? !favor_dbg : c_ok;
      if (take_core) begin
        e_cg = 1; e_a3 = core_addr; e_wd = core_data; e_we = (core_addr != 0);
      end else begin
        e_dg = 1; e_a3 = dbg_addr; e_wd = dbg_data; e_we = (dbg_addr != 0);
      end
      favor_dbg = take_core;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rf_we", rf_we, e_we);
    chk("rf_a3", rf_a3, e_a3);
    chk("rf_wd", rf_wd, e_wd);
    chk("core_gnt", core_gnt, e_cg);
    chk("dbg_gnt", dbg_gnt, e_dg);
    chk("clr_busy", clr_busy, e_busy);
    chk("clr_done", clr_done, e_done);
    chk("we_to_x0", rf_we && (rf_a3 == 0), 0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    else model_reset();
    #1;
    check_all();
  endtask

  initial begin
    int nw, nd;
    model_reset();
    #1;
    check_all();
    step();
    step();
    @(negedge clk);
    rst = 1'b1;

    // Single core request held through two grants
    core_req = 1; core_addr = 5; core_data = 32'hDEADBEEF;
    step();
    chk("tp1_gnt", core_gnt, 1);
    chk("tp1_a3", rf_a3, 5);
    chk("tp1_wd", rf_wd, 32'hDEADBEEF);
    step();
    chk("tp1_idle", core_gnt, 0);
    step();
    chk("tp1_regrant", core_gnt, 1);
    core_req = 0;
    step();

    // Reset again so the pointer favours core, then both request together
    #2 rst = 0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1;
    core_req = 1; core_addr = 3; core_data = 32'h0000_0C0C;
    dbg_req  = 1; dbg_addr  = 4; dbg_data  = 32'h0000_DBDB;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_core", core_gnt, (i % 2 == 0));
      chk("rr_dbg", dbg_gnt, (i % 2 == 1));
    end
    core_req = 0; dbg_req = 0;
    step();

    // Debug write to x0 is consumed without a file write
    dbg_req = 1; dbg_addr = 0; dbg_data = 32'h1234;
    step();
    chk("x0_gnt", dbg_gnt, 1);
    chk("x0_we", rf_we, 0);
    dbg_req = 0;
    step();

    // Clear with a core request pending; a second clr_start mid-clear is ignored
    clr_start = 1; core_req = 1; core_addr = 9; core_data = 32'hCAFE_0009;
    nw = 0; nd = 0;
    for (int i = 0; i < 31; i++) begin
      step();
      clr_start = (i == 14);
      if (rf_we && clr_busy) nw++;
      if (clr_done) nd++;
    end
    chk("clr_writes", nw, 31);
    chk("clr_done_cnt", nd, 1);
    chk("clr_last_a3", rf_a3, 31);
    step();
    chk("post_clr_gnt", core_gnt, 1);
    core_req = 0;
    step();

    // Reset in the middle of a clear
    clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 0; i < 9; i++) step();
    chk("mid_clr_a3", rf_a3, 10);
    #2 rst = 0;
    #1 model_reset();
    check_all();
    step();
    step();
    @(negedge clk);
    rst = 1;
    step();
    chk("no_resume", clr_busy, 0);
    core_req = 1; core_addr = 7; core_data = 32'h7777;
    dbg_req  = 1; dbg_addr  = 8; dbg_data  = 32'h8888;
    step();
    chk("rst_ptr_core", core_gnt, 1);
    core_req = 0;
    step();
    dbg_req = 0;
    step();

    // Randomized traffic with the hold-until-grant handshake
    for (int i = 0; i < 600; i++) begin
      if (e_cg) begin
        core_req = ($urandom_range(0, 2) != 0);
        core_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        core_data = $urandom;
      end else if (!core_req && $urandom_range(0, 3) == 0) begin
        core_req = 1;
        core_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        core_data = $urandom;
      end
      if (e_dg) begin
        dbg_req = ($urandom_range(0, 2) != 0);
        dbg_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        dbg_data = $urandom;
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1;
        dbg_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        dbg_data = $urandom;
      end
      clr_start = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
